// File: rtl/julia_iter_engine_if.sv
// Scanner-to-engine handshake bundle for julia_iter_engine.
// Optional abort line is present only when JULIA_ABORT_EN is defined.
interface julia_iter_engine_if #(
  parameter int W     = 32,
  parameter int ITE_W = 16
);
  // Handshake: start is honoured only while busy is low (engine idle);
  // busy rises on the accepting edge and drops with the one-cycle done pulse,
  // from which out_color/out_ite/out_escaped are valid and held.
  logic                    start;
  logic signed [W-1:0]     in_x;
  logic signed [W-1:0]     in_y;
  logic signed [W-1:0]     cr;
  logic signed [W-1:0]     ci;
  logic [1:0]              color_mode;
  logic                    busy;
  logic                    done;
  logic [15:0]             out_color;
  logic [ITE_W-1:0]        out_ite;
  logic                    out_escaped;
`ifdef JULIA_ABORT_EN
  logic                    abort;
`endif

  modport master (
`ifdef JULIA_ABORT_EN
    output abort,
`endif
    output start, in_x, in_y, cr, ci, color_mode,
    input  busy, done, out_color, out_ite, out_escaped
  );

  modport slave (
`ifdef JULIA_ABORT_EN
    input  abort,
`endif
    input  start, in_x, in_y, cr, ci, color_mode,
    output busy, done, out_color, out_ite, out_escaped
  );
endinterface

// File: rtl/julia_iter_engine.sv
// Julia per-pixel iteration engine with internal complex-square datapath.
// Optional JULIA_ABORT_EN adds an abort input that cuts an iteration short.
module julia_iter_engine #(
  parameter int             W       = 32,
  parameter int             FRAC    = 24,
  parameter int             ITE_W   = 16,
  parameter int             ITE_MAX = 255,
  parameter logic [W-1:0]   E_LIMIT = W'(32'h0400_0000)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  julia_iter_engine_if.slave   bus,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_SUM    = 3'd2,
    S_JUDGE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam int            PW    = 2 * W;
  localparam int            EW    = ITE_W + 17;
  localparam logic [PW:0]   LIMIT = (PW+1)'(E_LIMIT) << FRAC;

  state_t                 state_q;
  logic signed [W-1:0]    x_q, y_q, cr_q, ci_q, nx_q, ny_q;
  logic [1:0]             mode_q;
  logic [ITE_W-1:0]       ite_q;
  logic signed [PW-1:0]   xx_q, yy_q, xy_q;
  logic [PW:0]            mag_q;
  logic                   esc_q, abort_q;
  logic                   busy_q, done_q, out_esc_q;
  logic [15:0]            out_color_q;
  logic [ITE_W-1:0]       out_ite_q;

  logic signed [PW-1:0]   xe, ye, diff_sh, dbl_sh;
  logic signed [W-1:0]    nx_d, ny_d;
  logic [PW:0]            mag_d;
  logic [EW-1:0]          ite_ext;
  logic [15:0]            c16, color_d;
  logic                   abort_hit;

`ifdef JULIA_ABORT_EN
  assign abort_hit = bus.abort &&
                     (state_q == S_MUL || state_q == S_SUM || state_q == S_JUDGE);
`else
  assign abort_hit = 1'b0;
`endif

  // Size casts sign-extend, so the PW-bit product is the exact signed square.
  assign xe      = PW'(x_q);
  assign ye      = PW'(y_q);
  assign diff_sh = (xx_q - yy_q) >>> FRAC;
  assign dbl_sh  = (xy_q <<< 1) >>> FRAC;
  assign nx_d    = diff_sh[W-1:0] + cr_q;
  assign ny_d    = dbl_sh[W-1:0] + ci_q;
  assign mag_d   = {1'b0, xx_q} + {1'b0, yy_q};

  assign ite_ext = EW'(ite_q);
  assign c16     = (ite_ext > EW'(17'h0FFFF)) ? 16'hFFFF : ite_ext[15:0];

  always_comb begin
    color_d = (c16 << 12) | (c16 << 8) | c16;
    case (mode_q)
      2'd1:    color_d = c16;
      2'd2:    color_d = (c16 << 10) | c16;
      default: color_d = (c16 << 12) | (c16 << 8) | c16;
    endcase
    if (!esc_q)  color_d = 16'h001F;
    if (abort_q) color_d = 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cr_q        <= '0;
      ci_q        <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      mode_q      <= '0;
      ite_q       <= '0;
      xx_q        <= '0;
      yy_q        <= '0;
      xy_q        <= '0;
      mag_q       <= '0;
      esc_q       <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_esc_q   <= 1'b0;
      out_color_q <= '0;
      out_ite_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q     <= bus.in_x;
            y_q     <= bus.in_y;
            cr_q    <= bus.cr;
            ci_q    <= bus.ci;
            mode_q  <= bus.color_mode;
            ite_q   <= '0;
            esc_q   <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (abort_hit) begin
            esc_q   <= 1'b0;
            abort_q <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            xx_q    <= xe * xe;
            yy_q    <= ye * ye;
            xy_q    <= xe * ye;
            state_q <= S_SUM;
          end
        end
        S_SUM: begin
          if (abort_hit) begin
            esc_q   <= 1'b0;
            abort_q <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            mag_q   <= mag_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            state_q <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          // Abort outranks escape; a magnitude exactly on the limit keeps iterating.
          if (abort_hit) begin
            esc_q   <= 1'b0;
            abort_q <= 1'b1;
            state_q <= S_FINISH;
          end else if (mag_q > LIMIT) begin
            esc_q   <= 1'b1;
            state_q <= S_FINISH;
          end else if (ite_q == ITE_W'(ITE_MAX)) begin
            esc_q   <= 1'b0;
            state_q <= S_FINISH;
          end else begin
            x_q     <= nx_q;
            y_q     <= ny_q;
            ite_q   <= ite_q + 1'b1;
            state_q <= S_MUL;
          end
        end
        S_FINISH: begin
          out_color_q <= color_d;
          out_ite_q   <= ite_q;
          out_esc_q   <= esc_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.out_color   = out_color_q;
  assign bus.out_ite     = out_ite_q;
  assign bus.out_escaped = out_esc_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_julia_iter_engine.sv
// Bench for julia_iter_engine: directed corner pixels plus random pixels
// against a plain-arithmetic reference of the escape-time iteration.
module tb_julia_iter_engine;

  localparam int          W       = 32;
  localparam int          FRAC    = 24;
  localparam int          ITE_W   = 16;
  localparam int          ITE_MAX = 255;
  localparam logic [31:0] E_LIMIT = 32'h0400_0000;
  localparam int          ONE     = 32'h0100_0000;
  localparam int          HALF    = 32'h0080_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         tests = 0;
  int         fails = 0;
  logic [32:0] exp_q[$];

  julia_iter_engine_if #(.W(W), .ITE_W(ITE_W)) bus ();

  julia_iter_engine #(
    .W(W), .FRAC(FRAC), .ITE_W(ITE_W), .ITE_MAX(ITE_MAX), .E_LIMIT(E_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Escape-time iteration in 64-bit integer arithmetic; returns {escaped, ite, colour}.
  function automatic logic [32:0] ref_pixel(input int x0, input int y0,
                                            input int c_r, input int c_i, input int mode);
    longint      x, y, xx, yy, xy;
    logic [64:0] mag, lim;
    int          ite;
    bit          esc;
    logic [15:0] c, col;
    x = x0; y = y0; ite = 0; esc = 0;
    lim = 65'(E_LIMIT) << FRAC;
    while (1) begin
      xx  = x * x;
      yy  = y * y;
      xy  = x * y;
      mag = 65'(xx) + 65'(yy);
      if (mag > lim) begin esc = 1; break; end
      if (ite == ITE_MAX) break;
      x = longint'(int'(((xx - yy) >>> FRAC) + c_r));
      y = longint'(int'(((xy * 2) >>> FRAC) + c_i));
      ite++;
    end
    c = ite[15:0];
    case (mode)
      1:       col = c;
      2:       col = (c << 10) | c;
      default: col = (c << 12) | (c << 8) | c;
    endcase
    if (!esc) col = 16'h001F;
    return {esc, c, col};
  endfunction

  // ---------------- driver ----------------
  task automatic run_pixel(input string tag, input int x0, input int y0,
                           input int c_r, input int c_i, input int mode,
                           input int restart_at);
    logic [32:0] exp;
    int          lat;
    bit          seen;
    exp_q.push_back(ref_pixel(x0, y0, c_r, c_i, mode));
    @(negedge clk);
    bus.in_x = x0; bus.in_y = y0; bus.cr = c_r; bus.ci = c_i;
    bus.color_mode = 2'(mode);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_x = ~x0; bus.in_y = ~y0; bus.cr = ~c_r; bus.ci = ~c_i;
    bus.color_mode = 2'(mode + 1);
    check({tag, "_busy"}, bus.busy, 1'b1);
    check({tag, "_done_low"}, bus.done, 1'b0);
    lat = 0; seen = 0;
    while (!seen && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      bus.start = (lat == restart_at);
      seen = bus.done;
    end
    bus.start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "_ite"},     bus.out_ite,     exp[31:16]);
      check({tag, "_escaped"}, bus.out_escaped, exp[32]);
      check({tag, "_color"},   bus.out_color,   exp[15:0]);
      check({tag, "_latency"}, lat,             3 * (int'(exp[31:16]) + 1) + 1);
      check({tag, "_busy_off"}, bus.busy,       1'b0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    bus.busy,        1'b0);
    check({tag, "_done"},    bus.done,        1'b0);
    check({tag, "_color"},   bus.out_color,   16'h0000);
    check({tag, "_ite"},     bus.out_ite,     16'h0000);
    check({tag, "_escaped"}, bus.out_escaped, 1'b0);
    check({tag, "_state"},   dbg_state,       3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.cr = '0; bus.ci = '0;
    bus.color_mode = 2'd0;
`ifdef JULIA_ABORT_EN
    bus.abort = 1'b0;
`endif
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_pixel("origin_max",   0, 0, 0, 0, 0, -1);
    run_pixel("x3_escape",    3 * ONE, 0, 0, 0, 0, -1);
    run_pixel("x1p5_grey",    ONE + HALF, 0, 0, 0, 0, -1);
    run_pixel("x1p5_blue",    ONE + HALF, 0, 0, 0, 1, -1);
    run_pixel("x1p5_devil",   ONE + HALF, 0, 0, 0, 2, -1);
    run_pixel("x2_boundary",  2 * ONE, 0, 0, 0, 3, -1);
    run_pixel("qmodel",       0, -(ONE + HALF), -HALF, ONE / 4, 1, -1);
    run_pixel("restart_ign",  ONE + HALF, 0, 0, 0, 0, 2);

    // Asynchronous reset while the engine sits in SUM.
    @(negedge clk);
    bus.in_x = 0; bus.in_y = 0; bus.cr = 0; bus.ci = 0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    check("mid_sum_state", dbg_state, 3'd2);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_pixel("post_reset",   ONE + HALF, 0, 0, 0, 2, -1);

    for (int i = 0; i < 20; i++) begin
      int rx, ry, rcr, rci, rm;
      rx  = int'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
      ry  = int'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
      rcr = int'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
      rci = int'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
      rm  = int'($urandom_range(0, 3));
      run_pixel($sformatf("rand%0d", i), rx, ry, rcr, rci, rm, -1);
    end

`ifdef JULIA_ABORT_EN
    begin
      int  lat;
      bit  seen;
      @(negedge clk);
      bus.in_x = 0; bus.in_y = 0; bus.cr = 0; bus.ci = 0;
      bus.color_mode = 2'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check("abort_finish_state", dbg_state, 3'd4);
      lat = 11; seen = 0;
      while (!seen && lat < 40) begin
        @(posedge clk); #1;
        lat++;
        seen = bus.done;
      end
      check("abort_done_seen", seen, 1'b1);
      check("abort_latency",   lat, 12);
      check("abort_color",     bus.out_color, 16'h0000);
      check("abort_escaped",   bus.out_escaped, 1'b0);
      check("abort_ite",       bus.out_ite, 16'd3);
    end
    run_pixel("after_abort", ONE + HALF, 0, 0, 0, 0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/julia_iter_engine.md
Name: julia_iter_engine

Overview:
Parametrised successor of the Julia per-pixel iteration controller. It holds the complex-square datapath internally, so no external calculator is needed. Fixed-point width, fraction bits, iteration cap and escape limit are generics, and the colour-mapping mode is runtime-selectable. It sits between the pixel scanner, which supplies z0 and c with a start pulse, and the frame-buffer writer, which consumes the done, colour and iteration-count outputs.

Parameters:
W, 32, signed fixed-point width of x, y, cr, ci
FRAC, 24, fraction bits (Q(W-FRAC).FRAC)
ITE_W, 16, iteration counter width
ITE_MAX, 255, last iteration index judged before giving up
E_LIMIT, 32'h0400_0000, escape threshold on |z|^2 in input Q format (4.0 at defaults)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only in IDLE
in_x  in  W  Re(z0), signed
in_y  in  W  Im(z0), signed
cr  in  W  Re(c), signed
ci  in  W  Im(c), signed
color_mode  in  2  0=grey, 1=blue, 2=devil, 3=grey
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse; results valid from this cycle
out_color  out  16  RGB565 colour
out_ite  out  ITE_W  final iteration index
out_escaped  out  1  1 = escaped; 0 = hit ITE_MAX

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, out_color, out_ite, out_escaped, ite, x, y all 0.
- States: IDLE, MUL, SUM, JUDGE, FINISH.
- IDLE:
  - start=1 captures in_x, in_y, cr, ci and color_mode; sets ite=0, busy=1; goes to MUL.
  - start is ignored in every other state; inputs are not re-sampled.
- MUL: registers full 2W-bit signed products xx=x*x, yy=y*y, xy=x*y.
- SUM:
  - mag = xx+yy at 2W+1 bits, unsigned (no overflow).
  - nx = ((xx-yy)>>>FRAC) + cr, truncated to W bits (wraps).
  - ny = ((xy<<<1)>>>FRAC) + ci, truncated to W bits (wraps).
- JUDGE, priority order:
  - mag > (E_LIMIT<<FRAC), strictly greater: out_escaped=1, go to FINISH.
  - else ite==ITE_MAX: out_escaped=0, go to FINISH.
  - else x<=nx, y<=ny, ite<=ite+1, go to MUL.
- FINISH:
  - c16 = ite saturated to 16'hFFFF (matters only when ITE_W>16).
  - out_ite = ite; out_color per captured mode, truncated to 16 bits:
    - grey: (c16<<12)|(c16<<8)|c16
    - blue: c16
    - devil: (c16<<10)|c16
    - non-escaped override: 16'h001F regardless of mode.
  - Next state IDLE. done=1 and busy=0 in the cycle after FINISH; done lasts one cycle.
  - out_color, out_ite and out_escaped hold until the next FINISH or reset.
- Latency: k judged iterations (k = out_ite+1) puts done high 3k+1 clocks after the start-accept edge.
- A start asserted in the same cycle done is high is accepted (state is IDLE).
- Throughput: one pixel in flight at a time.

Optional Feature:
JULIA_ABORT_EN
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in MUL, SUM or JUDGE forces FINISH on the next edge with out_escaped=0, out_color=16'h0000 and out_ite = current ite; done is then pulsed normally.
  - Abort wins over a simultaneous JUDGE escape. Abort in IDLE or FINISH has no effect.
- Undefined: no abort port; the engine always runs to escape or ITE_MAX.

Test Plan:
- z0=(0,0), c=(0,0), ITE_MAX=255, mode 0: start -> done 769 clocks later, out_escaped=0, out_ite=255, out_color=16'h001F.
- z0=(3.0,0), c=0: start -> done 4 clocks later, out_escaped=1, out_ite=0, out_color=16'h0000.
- z0=(1.5,0), c=0, run once per mode 0/1/2: out_ite=1, out_escaped=1, out_color=16'h1101 / 16'h0001 / 16'h0401; done at 7 clocks.
- z0=(2.0,0), c=0, boundary: mag=4.0 is not > limit so iteration continues; escapes with out_ite=1. Also z0=(0,-1.5), c=(-0.5,0.25): check against a bit-exact Q8.24 software model.
- Pulse start again 2 clocks after acceptance: ignored, result unchanged. Drop rst_n mid-SUM: outputs go to 0 asynchronously. After release, a new start completes normally.
- JULIA_ABORT_EN with z0=0, c=0: abort 10 clocks after start -> FINISH next edge, done pulse, out_color=16'h0000, out_escaped=0.
